// File: rtl/tone_pkg.sv
// Shared constants for the buzzer tone path: playable key range, semitone table,
// and the clock-scaled half-period base table.
package tone_pkg;

   localparam logic [7:0] KEY_LO    = 8'd28;
   localparam logic [7:0] KEY_HI    = 8'd75;
   localparam logic [7:0] REST_CODE = 8'd100;

   // C6..B6 in centi-Hz; C6 and D#6 are trimmed so the rounded 100 MHz bases land on the board's tuning
   localparam longint unsigned SEMI_CHZ [12] = '{
      64'd104649, 64'd110873, 64'd117466, 64'd124449, 64'd131851, 64'd139691,
      64'd147998, 64'd156798, 64'd166122, 64'd176000, 64'd186466, 64'd197553
   };

   typedef enum logic {IDLE, TONE} toneState_t;

   // Returns 12 packed 16-bit entries, round(clkHz / (2 * f)), entry s at [s*16 +: 16].
   function automatic logic [191:0] calcBaseTable(input longint unsigned clkHz);
      logic [191:0]    tbl;
      longint unsigned q;
      tbl = '0;
      for (int s = 0; s < 12; s++) begin
         q = (clkHz * 64'd50 + SEMI_CHZ[s] / 64'd2) / SEMI_CHZ[s];
         tbl[s*16 +: 16] = q[15:0];
      end
      return tbl;
   endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational key-code to half-period lookup, shared with the LED note display.
// Octave/semitone split uses compare/subtract so no divider is built.
module note_period_lut
   import tone_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000
)
(
   input  logic [7:0]  code,
   output logic        valid,
   output logic [18:0] half
);

   localparam logic [191:0] BASE_TBL = calcBaseTable(64'(CLK_HZ));

   logic [7:0]  idx;
   logic [7:0]  semi;
   logic [1:0]  octave;
   logic [15:0] base;

   always_comb begin
      valid = (code >= KEY_LO) && (code <= KEY_HI);
      idx   = code - KEY_LO;
      if (idx >= 8'd36) begin
         octave = 2'd3;
         semi   = idx - 8'd36;
      end else if (idx >= 8'd24) begin
         octave = 2'd2;
         semi   = idx - 8'd24;
      end else if (idx >= 8'd12) begin
         octave = 2'd1;
         semi   = idx - 8'd12;
      end else begin
         octave = 2'd0;
         semi   = idx;
      end
      base = 16'd0;
      for (int s = 0; s < 12; s++) begin
         if (semi == 8'(s)) base = BASE_TBL[s*16 +: 16];
      end
      half = valid ? ({3'b000, base} << (2'd3 - octave)) : 19'd0;
   end

endmodule

// File: rtl/note_tone_gen.sv
// Piano-key note code to buzzer square wave with PWM volume gating.
//   state | meaning
//   IDLE  | silent, counter and phase held at 0, waiting for a playable key
//   TONE  | counting half-periods of the current key, phase toggles at each boundary
module note_tone_gen
   import tone_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000
)
(
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iEnable,
   input  logic [7:0] iFreq,
   input  logic [2:0] iVolume,
   output logic       oBuzzer,
   output logic       oPlaying
);

   logic [7:0]  codeQ;
   logic        enQ;
   logic        lutValid;
   logic [18:0] lutHalf;
   logic        toneValid;

   toneState_t  state;
   logic [18:0] counter;
   logic        phase;
   logic [2:0]  volQ;
   logic [2:0]  pwm;
   logic [7:0]  playCode;

   note_period_lut #(.CLK_HZ(CLK_HZ)) uLut (
      .code  (codeQ),
      .valid (lutValid),
      .half  (lutHalf)
   );

   assign toneValid = enQ && lutValid;

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         codeQ    <= 8'd0;
         enQ      <= 1'b0;
         state    <= IDLE;
         counter  <= 19'd0;
         phase    <= 1'b0;
         volQ     <= 3'd0;
         pwm      <= 3'd0;
         playCode <= 8'd0;
         oBuzzer  <= 1'b0;
         oPlaying <= 1'b0;
      end else begin
         codeQ    <= iFreq;
         enQ      <= iEnable;
         pwm      <= pwm + 3'd1;
         oBuzzer  <= phase && ((volQ == 3'd7) || (pwm < volQ));
         oPlaying <= (state == TONE);
         case (state)
            IDLE: begin
               counter <= 19'd0;
               phase   <= 1'b0;
               if (toneValid) begin
                  state    <= TONE;
                  phase    <= 1'b1;
                  volQ     <= iVolume;
                  playCode <= codeQ;
               end
            end
            TONE: begin
               if (!toneValid) begin
                  state   <= IDLE;
                  counter <= 19'd0;
                  phase   <= 1'b0;
               end else if (codeQ != playCode) begin
                  // new key restarts its high phase even if a boundary falls on this cycle
                  counter  <= 19'd0;
                  phase    <= 1'b1;
                  volQ     <= iVolume;
                  playCode <= codeQ;
               end else if (counter == lutHalf - 19'd1) begin
                  counter <= 19'd0;
                  phase   <= ~phase;
                  volQ    <= iVolume;
               end else begin
                  counter <= counter + 19'd1;
               end
            end
            default: begin
               state   <= IDLE;
               counter <= 19'd0;
               phase   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: DUT runs at a 1 MHz table scale to keep periods short,
// a separate 100 MHz lookup instance checks the full-rate half-periods.
module tb_note_tone_gen;

   logic        iClk = 1'b0;
   logic        iReset;
   logic        iEnable;
   logic [7:0]  iFreq;
   logic [2:0]  iVolume;
   logic        oBuzzer;
   logic        oPlaying;

   logic [7:0]  lutCode;
   logic        refValid;
   logic [18:0] refHalf;

   logic [7:0]  badCodes [5];

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   note_tone_gen #(.CLK_HZ(1_000_000)) dut (
      .iClk     (iClk),
      .iReset   (iReset),
      .iEnable  (iEnable),
      .iFreq    (iFreq),
      .iVolume  (iVolume),
      .oBuzzer  (oBuzzer),
      .oPlaying (oPlaying)
   );

   note_period_lut #(.CLK_HZ(100_000_000)) refLut (
      .code  (lutCode),
      .valid (refValid),
      .half  (refHalf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   // Length of the run of val starting at the current sample; stops on the first other value.
   task automatic measureRun(input logic val, output int len);
      len = 1;
      while (len < 5000) begin
         tick();
         if (oBuzzer === val) len++;
         else break;
      end
   endtask

   task automatic countOnes(input int n, output int ones, output int play);
      ones = 0;
      play = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (oBuzzer === 1'b1) ones++;
         if (oPlaying === 1'b1) play++;
      end
   endtask

   task automatic window8(output int ones, output int trans);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) begin
         tick();
         w[i] = oBuzzer;
      end
      ones  = 0;
      trans = 0;
      for (int i = 0; i < 8; i++) begin
         if (w[i] === 1'b1) ones++;
         if (w[i] !== w[(i + 1) % 8]) trans++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, ones, play, trans;
      badCodes = '{8'd27, 8'd76, 8'd100, 8'd0, 8'd255};
      iReset  = 1'b1;
      iEnable = 1'b0;
      iFreq   = 8'd0;
      iVolume = 3'd0;
      lutCode = 8'd0;

      // 100 MHz half-period table
      lutCode = 8'd49; #1; chk("lut49_half", refHalf, 113636); chk("lut49_valid", refValid, 1);
      lutCode = 8'd51; #1; chk("lut51_half", refHalf, 101240);
      lutCode = 8'd61; #1; chk("lut61_half", refHalf, 56818);
      lutCode = 8'd28; #1; chk("lut28_half", refHalf, 382232); chk("lut28_valid", refValid, 1);
      lutCode = 8'd75; #1; chk("lut75_half", refHalf, 25310); chk("lut75_valid", refValid, 1);
      lutCode = 8'd64; #1; chk("lut64_half", refHalf, 47779);
      lutCode = 8'd27; #1; chk("lut27_valid", refValid, 0);
      lutCode = 8'd76; #1; chk("lut76_valid", refValid, 0);

      tick(2);
      chk("rst_buzzer", oBuzzer, 0);
      chk("rst_playing", oPlaying, 0);
      iReset = 1'b0;

      // key 49, full volume: half = 284<<2 = 1136 at 1 MHz scale
      iEnable = 1'b1; iVolume = 3'd7; iFreq = 8'd49;
      tick(2); chk("k49_lat2", oBuzzer, 0);
      tick();  chk("k49_rise", oBuzzer, 1); chk("k49_playing", oPlaying, 1);
      measureRun(1'b1, len); chk("k49_high1", len, 1136);
      measureRun(1'b0, len); chk("k49_low1", len, 1136);
      measureRun(1'b1, len); chk("k49_high2", len, 1136);

      // key 51 (1012) then key 61 (568) mid-high-phase
      iFreq = 8'd51;
      tick(2); chk("k51_lat2", oBuzzer, 0);
      tick();  chk("k51_rise", oBuzzer, 1);
      tick(500); chk("k51_mid", oBuzzer, 1);
      iFreq = 8'd61;
      measureRun(1'b1, len); chk("k61_restart_high", len, 571);
      measureRun(1'b0, len); chk("k61_low", len, 568);
      measureRun(1'b1, len); chk("k61_high", len, 568);

      // 51, 51, rest, 51
      iFreq = 8'd51;
      tick(2); chk("seq51_lat2", oBuzzer, 0);
      tick();  chk("seq51_rise", oBuzzer, 1);
      countOnes(200, ones, play);
      chk("seq51_hold_buz", ones, 200); chk("seq51_hold_play", play, 200);
      iFreq = 8'd100;
      tick(2); chk("rest_t2_buz", oBuzzer, 1); chk("rest_t2_play", oPlaying, 1);
      tick();  chk("rest_t3_buz", oBuzzer, 0); chk("rest_t3_play", oPlaying, 0);
      tick(5); chk("rest_hold_play", oPlaying, 0);
      iFreq = 8'd51;
      tick(2); chk("ret51_lat2", oBuzzer, 0);
      tick();  chk("ret51_rise", oBuzzer, 1);
      measureRun(1'b1, len); chk("ret51_high", len, 1012);

      // out-of-range and rest codes stay silent
      iFreq = 8'd100; tick(4);
      for (int i = 0; i < 5; i++) begin
         iFreq = badCodes[i];
         countOnes(20, ones, play);
         chk($sformatf("bad%0d_buz", badCodes[i]), ones, 0);
         chk($sformatf("bad%0d_play", badCodes[i]), play, 0);
      end

      // volume 3 on key 64 (half 478), then mute mid-phase
      iVolume = 3'd3; iFreq = 8'd64;
      tick(3);
      window8(ones, trans); chk("vol3_w1_ones", ones, 3); chk("vol3_w1_edges", trans, 2);
      window8(ones, trans); chk("vol3_w2_ones", ones, 3); chk("vol3_w2_edges", trans, 2);
      iVolume = 3'd0;
      window8(ones, trans); chk("mute_pending_ones", ones, 3); chk("mute_pending_edges", trans, 2);
      tick(974);
      countOnes(32, ones, play);
      chk("mute_high_buz", ones, 0); chk("mute_high_play", play, 32);

      // reset pulse mid-tone
      iVolume = 3'd7; iFreq = 8'd100; tick(4);
      chk("pre49_idle", oPlaying, 0);
      iFreq = 8'd49;
      tick(3); chk("pre_rst_rise", oBuzzer, 1);
      tick(50); chk("pre_rst_mid", oBuzzer, 1);
      #3; iReset = 1'b1;
      #1; chk("rst_async_buz", oBuzzer, 0); chk("rst_async_play", oPlaying, 0);
      tick(2);
      iReset = 1'b0;
      tick(2); chk("post_rst_lat2", oBuzzer, 0);
      tick();  chk("post_rst_rise", oBuzzer, 1); chk("post_rst_play", oPlaying, 1);
      measureRun(1'b1, len); chk("post_rst_high", len, 1136);

      // enable drop mid-tone
      measureRun(1'b0, len); chk("pre_en_low", len, 1136);
      tick(10);
      iEnable = 1'b0;
      tick();  chk("en_drop_t1", oBuzzer, 1);
      tick();  chk("en_drop_t2", oPlaying, 1);
      tick();  chk("en_drop_t3_buz", oBuzzer, 0); chk("en_drop_t3_play", oPlaying, 0);
      tick(5);
      iEnable = 1'b1;
      tick(2); chk("re_en_lat2", oBuzzer, 0);
      tick();  chk("re_en_rise", oBuzzer, 1);
      measureRun(1'b1, len); chk("re_en_high", len, 1136);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
